// File: rtl/eda_pkg.sv
// eda_pkg -- shared definitions for the regional-maxima engine.
//
// Contents:
//   CFG_*            default frame geometry and pixel width
//   scan_state_e     raster scanner FSM states (IDLE, SCAN, DRAIN)
//   WIN_*            window slot indices; slot k sits at [k*PIXEL_WIDTH +: PIXEL_WIDTH]
//   MASK_SLOT_MAP    neighbour-valid mask bit -> window slot (4 bits per entry)
//   mask_slot()      lookup helper for MASK_SLOT_MAP
package eda_pkg;

   localparam int CFG_M            = 3;
   localparam int CFG_N            = 3;
   localparam int CFG_PIXEL_WIDTH  = 8;
   localparam int CFG_WINDOW_WIDTH = 9;
   localparam int CFG_I_WIDTH      = 2;
   localparam int CFG_J_WIDTH      = 2;
   localparam int CFG_ADDR_WIDTH   = CFG_I_WIDTH + CFG_J_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } scan_state_e;

   localparam int WIN_UL = 8;
   localparam int WIN_U  = 7;
   localparam int WIN_UR = 6;
   localparam int WIN_L  = 5;
   localparam int WIN_C  = 4;
   localparam int WIN_R  = 3;
   localparam int WIN_DL = 2;
   localparam int WIN_D  = 1;
   localparam int WIN_DR = 0;

   localparam int NUM_NEIGH = 8;

   // The center slot has no mask bit, so mask bits 7..4 land on slots 8..5
   // and bits 3..0 land on slots 3..0. Entry b is at [b*4 +: 4].
   localparam logic [4*NUM_NEIGH-1:0] MASK_SLOT_MAP = {
      4'd8, 4'd7, 4'd6, 4'd5, 4'd3, 4'd2, 4'd1, 4'd0
   };

   function automatic int mask_slot(input int b);
      return int'(MASK_SLOT_MAP[b*4 +: 4]);
   endfunction

endpackage

// File: rtl/eda_max_compare.sv
// eda_max_compare -- combinational local-maximum test on a 3x3 window.
//
// Ports:
//   window_i   PIXEL_WIDTH*WINDOW_WIDTH  window slots, slot 4 is the center
//   mask_i     WINDOW_WIDTH-1            neighbour-valid bits (bit 7 upleft .. bit 0 downright)
//   strict_i   1                         1: center > neighbours, 0: center >= neighbours
//   is_max_o   1                         center passes the test against every valid neighbour
//
// Invalid neighbours never influence the result, whatever value they carry.
module eda_max_compare
   import eda_pkg::*;
#(
   parameter int PIXEL_WIDTH  = CFG_PIXEL_WIDTH,
   parameter int WINDOW_WIDTH = CFG_WINDOW_WIDTH
) (
   input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_i,
   input  logic [WINDOW_WIDTH-2:0]             mask_i,
   input  logic                                strict_i,
   output logic                                is_max_o
);

   logic [PIXEL_WIDTH-1:0] center;
   logic [PIXEL_WIDTH-1:0] neigh;
   int                     slot;

   always_comb begin
      is_max_o = 1'b1;
      center   = window_i[WIN_C*PIXEL_WIDTH +: PIXEL_WIDTH];
      neigh    = '0;
      slot     = 0;
      for (int b = 0; b < WINDOW_WIDTH-1; b++) begin
         slot  = mask_slot(b);
         neigh = window_i[slot*PIXEL_WIDTH +: PIXEL_WIDTH];
         if (mask_i[b]) begin
            if (strict_i ? (center <= neigh) : (center < neigh)) begin
               is_max_o = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/eda_window_scanner.sv
// eda_window_scanner -- raster-order reader for the image RAM.
//
// Steps center_addr = {i, j} over an M x N frame, samples the combinational
// 3x3 window returned by the RAM in the same cycle and reports one
// regional-maximum flag per pixel on a valid/ready stream.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   start              frame request, honoured only in IDLE
//   center_addr        {i, j} to the RAM (registered)
//   window_values      3x3 window from the RAM, slot 4 is the center
//   neigh_addr_valid   neighbour-valid mask from the RAM
//   out_valid/ready    result stream handshake
//   out_addr           address of the reported pixel
//   out_center         center pixel value
//   out_is_max         local-maximum flag
//   busy               FSM not in IDLE
//   done               one-cycle pulse after the last result is accepted
//   dbg_state          current FSM state
//
// Handshake: a result transfers on every rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 all out_* hold.
//
// Build option: define EDA_SCAN_STRICT_EN to make the test center > every
// valid neighbour (plateaus are not maxima); otherwise center >= is used.
module eda_window_scanner
   import eda_pkg::*;
#(
   parameter int M            = CFG_M,
   parameter int N            = CFG_N,
   parameter int PIXEL_WIDTH  = CFG_PIXEL_WIDTH,
   parameter int WINDOW_WIDTH = CFG_WINDOW_WIDTH,
   parameter int ADDR_WIDTH   = CFG_ADDR_WIDTH,
   parameter int I_WIDTH      = CFG_I_WIDTH,
   parameter int J_WIDTH      = CFG_J_WIDTH
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                start,
   output logic [ADDR_WIDTH-1:0]               center_addr,
   input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
   input  logic [WINDOW_WIDTH-2:0]             neigh_addr_valid,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [ADDR_WIDTH-1:0]               out_addr,
   output logic [PIXEL_WIDTH-1:0]              out_center,
   output logic                                out_is_max,
   output logic                                busy,
   output logic                                done,
   output scan_state_e                         dbg_state
);

   localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M-1);
   localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N-1);

`ifdef EDA_SCAN_STRICT_EN
   localparam logic STRICT = 1'b1;
`else
   localparam logic STRICT = 1'b0;
`endif

   scan_state_e              state_q, state_d;
   logic [I_WIDTH-1:0]       i_q, i_d;
   logic [J_WIDTH-1:0]       j_q, j_d;
   logic                     out_valid_q, out_valid_d;
   logic [ADDR_WIDTH-1:0]    out_addr_q, out_addr_d;
   logic [PIXEL_WIDTH-1:0]   out_center_q, out_center_d;
   logic                     out_is_max_q, out_is_max_d;
   logic                     done_q, done_d;

   logic                     capture;
   logic                     is_max_w;

   eda_max_compare #(
      .PIXEL_WIDTH  (PIXEL_WIDTH),
      .WINDOW_WIDTH (WINDOW_WIDTH)
   ) u_cmp (
      .window_i (window_values),
      .mask_i   (neigh_addr_valid),
      .strict_i (STRICT),
      .is_max_o (is_max_w)
   );

   // The output slot is free when empty or being drained this cycle.
   assign capture = (state_q == SCAN) && (!out_valid_q || out_ready);

   always_comb begin
      state_d      = state_q;
      i_d          = i_q;
      j_d          = j_q;
      out_valid_d  = out_valid_q && !out_ready;
      out_addr_d   = out_addr_q;
      out_center_d = out_center_q;
      out_is_max_d = out_is_max_q;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (capture) begin
               out_valid_d  = 1'b1;
               out_addr_d   = {i_q, j_q};
               out_center_d = window_values[WIN_C*PIXEL_WIDTH +: PIXEL_WIDTH];
               out_is_max_d = is_max_w;
               if (j_q == J_LAST) begin
                  j_d = '0;
                  if (i_q == I_LAST) begin
                     // Leave the address at {0,0} so the next frame starts there.
                     i_d     = '0;
                     state_d = DRAIN;
                  end else begin
                     i_d = i_q + 1'b1;
                  end
               end else begin
                  j_d = j_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (out_valid_q && out_ready) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         i_q          <= '0;
         j_q          <= '0;
         out_valid_q  <= 1'b0;
         out_addr_q   <= '0;
         out_center_q <= '0;
         out_is_max_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         i_q          <= i_d;
         j_q          <= j_d;
         out_valid_q  <= out_valid_d;
         out_addr_q   <= out_addr_d;
         out_center_q <= out_center_d;
         out_is_max_q <= out_is_max_d;
         done_q       <= done_d;
      end
   end

   assign center_addr = {i_q, j_q};
   assign out_valid   = out_valid_q;
   assign out_addr    = out_addr_q;
   assign out_center  = out_center_q;
   assign out_is_max  = out_is_max_q;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_eda_window_scanner.sv
// Testbench for eda_window_scanner on a 3x3 frame. Models the image RAM
// (combinational window + neighbour mask), keeps an expected queue built
// from a direct neighbourhood model of the image, and checks order,
// stability under back-pressure, done timing, reset and start handling.
module tb_eda_window_scanner;
   import eda_pkg::*;

   localparam int M  = 3;
   localparam int N  = 3;
   localparam int PW = 8;
   localparam int WW = 9;
   localparam int IW = 2;
   localparam int JW = 2;
   localparam int AW = IW + JW;
   localparam int EW = AW + PW + 1;

`ifdef EDA_SCAN_STRICT_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [AW-1:0]     center_addr;
   logic [PW*WW-1:0]  window_values;
   logic [WW-2:0]     neigh_addr_valid;
   logic              out_valid;
   logic              out_ready;
   logic [AW-1:0]     out_addr;
   logic [PW-1:0]     out_center;
   logic              out_is_max;
   logic              busy;
   logic              done;
   scan_state_e       dbg_state;

   always #5 clk = ~clk;

   eda_window_scanner #(
      .M (M), .N (N), .PIXEL_WIDTH (PW), .WINDOW_WIDTH (WW),
      .ADDR_WIDTH (AW), .I_WIDTH (IW), .J_WIDTH (JW)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .center_addr      (center_addr),
      .window_values    (window_values),
      .neigh_addr_valid (neigh_addr_valid),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_addr         (out_addr),
      .out_center       (out_center),
      .out_is_max       (out_is_max),
      .busy             (busy),
      .done             (done),
      .dbg_state        (dbg_state)
   );

   // ---------------- image RAM model ----------------
   logic [PW-1:0] img [M][N];
   logic          junk_en;
   logic [PW-1:0] junk_val;
   int            ram_ni, ram_nj, ram_mb;
   bit            ram_inb;

   // Slot k looks at row offset 1-k/3 and column offset 1-k%3.
   always_comb begin
      window_values    = '0;
      neigh_addr_valid = '0;
      ram_ni = 0; ram_nj = 0; ram_mb = 0; ram_inb = 1'b0;
      for (int k = 0; k < WW; k++) begin
         ram_ni  = int'(center_addr[AW-1:JW]) + 1 - k / 3;
         ram_nj  = int'(center_addr[JW-1:0]) + 1 - k % 3;
         ram_inb = (ram_ni >= 0) && (ram_ni < M) && (ram_nj >= 0) && (ram_nj < N);
         ram_mb  = (k > 4) ? k - 1 : k;
         if (ram_inb) begin
            window_values[k*PW +: PW] = img[ram_ni][ram_nj];
            if (k != 4) neigh_addr_valid[ram_mb] = 1'b1;
         end else begin
            window_values[k*PW +: PW] = junk_en ? junk_val : '0;
         end
      end
   end

   // ---------------- reference model / scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int vectors     = 0;
   int miscompares = 0;

   function automatic logic ref_max(input int i, input int j);
      logic ok = 1'b1;
      for (int di = -1; di <= 1; di++) begin
         for (int dj = -1; dj <= 1; dj++) begin
            if ((di != 0 || dj != 0) && i+di >= 0 && i+di < M && j+dj >= 0 && j+dj < N) begin
               if (STRICT ? !(img[i][j] > img[i+di][j+dj]) : (img[i][j] < img[i+di][j+dj]))
                  ok = 1'b0;
            end
         end
      end
      return ok;
   endfunction

   task automatic build_expected();
      logic [IW-1:0] ii;
      logic [JW-1:0] jj;
      exp_q.delete();
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < N; j++) begin
            ii = IW'(i);
            jj = JW'(j);
            exp_q.push_back({ii, jj, img[i][j], ref_max(i, j)});
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_img(input logic [9*PW-1:0] p);
      for (int r = 0; r < M*N; r++) img[r / N][r % N] = p[r*PW +: PW];
   endtask

   // ---------------- driver ----------------
   task automatic do_reset();
      reset_n   = 1'b0;
      start     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
   // start_mode: 0 one-cycle pulse, 1 held through frame, 2 held past done
   task automatic run_frame(input int ready_mode, input int start_mode,
                            input bit use_tab, input logic [8:0] tab_max);
      int            cyc = 1;
      int            done_cyc = -1;
      int            n_hs = 0;
      int            r;
      logic          prev_stall = 1'b0;
      logic [EW:0]   prev_out = '0;
      logic [EW-1:0] exp_e;
      logic [3:0]    pat = 4'b1001;
      build_expected();
      @(negedge clk);
      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("busy_cycle1", busy, 1);
      check("center_addr_cycle1", center_addr, 0);
      if (start_mode == 0) start = 1'b0;
      while (cyc < 400) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = pat[3 - ((cyc - 1) % 4)];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (prev_stall)
            check("stall_stable", {out_valid, out_addr, out_center, out_is_max}, prev_out);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_handshake", 1, 0);
            end else begin
               exp_e = exp_q.pop_front();
               check("result", {out_addr, out_center, out_is_max}, exp_e);
               if (use_tab) begin
                  r = int'(out_addr[AW-1:JW]) * N + int'(out_addr[JW-1:0]);
                  if (r < M*N) check("table_is_max", out_is_max, tab_max[r]);
               end
            end
            n_hs++;
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_valid, out_addr, out_center, out_is_max};
         @(negedge clk);
         cyc++;
      end
      if (done_cyc < 0) begin
         check("done_timeout", 0, 1);
      end else begin
         check("busy_with_done", busy, 0);
         check("handshake_count", n_hs, M*N);
         if (ready_mode == 0) check("done_cycle", done_cyc, M*N + 2);
         if (start_mode == 2) begin
            @(negedge clk);
            check("rescan_after_done", busy, 1);
            start = 1'b0;
         end else begin
            start = 1'b0;
            @(negedge clk);
            check("done_pulse", done, 0);
            check("idle_after_done", busy, 0);
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [9*PW-1:0] pix;          // pixel r=i*N+j at [r*PW +: PW]
      int              ready_mode;
      int              start_mode;
      logic [8:0]      exp_max;      // bit r: expected flag, >= test
      logic [8:0]      exp_max_strict;
   } vec_t;

   vec_t tab[6];

   initial begin
      tab[0] = '{{8'd1,8'd1,8'd1,8'd1,8'd9,8'd1,8'd1,8'd1,8'd1}, 0, 0, 9'h010, 9'h010};
      tab[1] = '{{8'd5,8'd5,8'd5,8'd5,8'd5,8'd5,8'd5,8'd5,8'd5}, 0, 0, 9'h1FF, 9'h000};
      tab[2] = '{{8'd0,8'd0,8'd0,8'd0,8'd3,8'd3,8'd0,8'd8,8'd7}, 0, 0, 9'h002, 9'h002};
      tab[3] = '{{8'd0,8'd0,8'd0,8'd0,8'd3,8'd3,8'd0,8'd3,8'd7}, 0, 0, 9'h001, 9'h001};
      tab[4] = '{{8'd1,8'd1,8'd1,8'd1,8'd9,8'd1,8'd1,8'd1,8'd1}, 1, 0, 9'h010, 9'h010};
      tab[5] = '{{8'd5,8'd5,8'd5,8'd5,8'd5,8'd5,8'd5,8'd5,8'd5}, 2, 1, 9'h1FF, 9'h000};

      junk_en   = 1'b0;
      junk_val  = '0;
      reset_n   = 1'b0;
      start     = 1'b0;
      out_ready = 1'b0;
      set_img('0);

      // reset state
      @(negedge clk);
      check("rst_center_addr", center_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_bundle", {out_addr, out_center, out_is_max}, 0);
      check("rst_busy_done", {busy, done}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // table-driven frames
      for (int t = 0; t < 6; t++) begin
         set_img(tab[t].pix);
         run_frame(tab[t].ready_mode, tab[t].start_mode, 1'b1,
                   STRICT ? tab[t].exp_max_strict : tab[t].exp_max);
         @(negedge clk);
      end

      // reset in the middle of a scan at address {1,0}
      begin
         int w = 0;
         set_img(tab[0].pix);
         start     = 1'b1;
         out_ready = 1'b1;
         @(negedge clk);
         start = 1'b0;
         while (center_addr != 4'b0100 && w < 20) begin
            @(negedge clk);
            w++;
         end
         check("reset_wait", (w < 20), 1);
         reset_n = 1'b0;
         #1;
         check("midrst_center_addr", center_addr, 0);
         check("midrst_outputs", {out_valid, out_addr, out_center, out_is_max}, 0);
         check("midrst_busy_done", {busy, done}, 0);
         check("midrst_state", dbg_state, IDLE);
         @(negedge clk);
         reset_n = 1'b1;
         @(negedge clk);
         check("post_rst_idle", busy, 0);
         run_frame(0, 0, 1'b1, STRICT ? tab[0].exp_max_strict : tab[0].exp_max);
      end

      // start held past done starts a second scan, then abandon it by reset
      set_img(tab[2].pix);
      run_frame(0, 2, 1'b1, STRICT ? tab[2].exp_max_strict : tab[2].exp_max);
      do_reset();

      // random frames: small pixel range for plateaus, junk in invalid slots
      junk_en = 1'b1;
      for (int f = 0; f < 8; f++) begin
         junk_val = PW'($urandom_range(128, 255));
         for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
               img[i][j] = PW'($urandom_range(0, 3));
         run_frame(2, f % 2, 1'b0, 9'h000);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
